// File: rtl/weights_fetch.sv
// Sweeps a 1-cycle-latency weights ROM over addresses 0..KERNEL_SIZE-1, packs the
// returned words into a flat kernel bus and offers it downstream via valid/ready.
module weights_fetch #(
  parameter int PARA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 25,
  parameter int ADDR_W      = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            rom_r_en,
  output logic [ADDR_W-1:0]               rom_raddr,
  input  logic [PARA_WIDTH-1:0]           rom_dout,
  output logic                            kernel_vld,
  input  logic                            kernel_rdy,
  output logic [KERNEL_SIZE*PARA_WIDTH-1:0] kernel_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KERNEL_SIZE - 1);

  if ((KERNEL_SIZE > (1 << ADDR_W)) || (KERNEL_SIZE < 1)) begin : g_param_err
    $error("weights_fetch: KERNEL_SIZE must be in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_cnt;
  logic [ADDR_W-1:0]     w_cnt_nxt;
  logic                  r_cap_en_p1;
  logic [ADDR_W-1:0]     r_cap_idx_p1;
  logic [PARA_WIDTH-1:0] r_slot [KERNEL_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are decoded from state so an async reset clears them at once.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    rom_r_en    = 1'b0;
    rom_raddr   = '0;
    kernel_vld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        rom_r_en  = 1'b1;
        rom_raddr = r_cnt;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_ADDR) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        busy       = 1'b1;
        kernel_vld = 1'b1;
        if (kernel_rdy) begin
          if (start) begin
            w_state_nxt = S_READ;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: read request delayed to line up with the ROM's returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_en_p1  <= 1'b0;
      r_cap_idx_p1 <= '0;
    end else begin
      r_cap_en_p1  <= rom_r_en;
      r_cap_idx_p1 <= rom_raddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_SIZE; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        if (r_cap_en_p1 && (r_cap_idx_p1 == ADDR_W'(i))) r_slot[i] <= rom_dout;
      end
    end
  end

  for (genvar g = 0; g < KERNEL_SIZE; g++) begin : g_pack
    assign kernel_data[g*PARA_WIDTH +: PARA_WIDTH] = r_slot[g];
  end

endmodule

// File: tb/tb_weights_fetch.sv
// Directed bench for weights_fetch with a 1-cycle-latency ROM model (word i = 16'h0100+i).
module tb_weights_fetch;

  localparam int PW = 16;
  localparam int K  = 25;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            rom_r_en;
  logic [AW-1:0]   rom_raddr;
  logic [PW-1:0]   rom_dout;
  logic            kernel_vld;
  logic            kernel_rdy;
  logic [K*PW-1:0] kernel_data;

  logic [PW-1:0] rom_mem [32];

  int n_total;
  int n_bad;

  weights_fetch #(.PARA_WIDTH(PW), .KERNEL_SIZE(K), .ADDR_W(AW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .rom_r_en   (rom_r_en),
    .rom_raddr  (rom_raddr),
    .rom_dout   (rom_dout),
    .kernel_vld (kernel_vld),
    .kernel_rdy (kernel_rdy),
    .kernel_data(kernel_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom_en_mux();

  function automatic logic [PW-1:0] rom_en_mux();
    return rom_r_en ? rom_mem[rom_raddr] : '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge following the edge that sampled start (k=0).
  task automatic watch(input int pa, input int pb, output int nreads,
                       output int first_k, output int vld_k);
    nreads  = 0;
    first_k = -1;
    vld_k   = -1;
    for (int k = 0; k < 40; k++) begin
      start = (k == pa) || (k == pb);
      if (rom_r_en) begin
        if (first_k < 0) first_k = k;
        chk("addr", 64'(rom_raddr), 64'(nreads));
        nreads++;
      end
      if (kernel_vld) begin
        vld_k = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_slots(input string tag, input bit all_ff);
    for (int i = 0; i < K; i++) begin
      chk($sformatf("%s[%0d]", tag, i), 64'(kernel_data[i*PW +: PW]),
          all_ff ? 64'hFFFF : 64'(16'h0100 + i));
    end
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nr, fk, vk, cnt_en, cnt_vld;
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'h0100 + 16'(i);
    rst_n      = 1'b0;
    start      = 1'b0;
    kernel_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ren", 64'(rom_r_en), 0);
    chk("rst_addr", 64'(rom_raddr), 0);
    chk("rst_vld", 64'(kernel_vld), 0);
    chk("rst_kdata", 64'(|kernel_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic fetch, consumer always ready
    kick();
    watch(-1, -1, nr, fk, vk);
    chk("t1_reads", 64'(nr), 25);
    chk("t1_first", 64'(fk), 0);
    chk("t1_vldk", 64'(vk), 26);
    check_slots("t1_slot", 1'b0);
    @(negedge clk);
    chk("t1_vld_drop", 64'(kernel_vld), 0);
    chk("t1_idle", 64'(busy), 0);

    // 2: consumer stalls for 10 cycles
    kernel_rdy = 1'b0;
    kick();
    watch(-1, -1, nr, fk, vk);
    chk("t2_vldk", 64'(vk), 26);
    for (int c = 0; c < 10; c++) begin
      chk("t2_hold_vld", 64'(kernel_vld), 1);
      chk("t2_hold_ren", 64'(rom_r_en), 0);
      chk("t2_hold_s0", 64'(kernel_data[0 +: PW]), 64'h0100);
      chk("t2_hold_s24", 64'(kernel_data[24*PW +: PW]), 64'h0118);
      @(negedge clk);
    end
    kernel_rdy = 1'b1;
    @(negedge clk);
    chk("t2_vld_drop", 64'(kernel_vld), 0);
    chk("t2_idle", 64'(busy), 0);

    // 3: start on the handshake cycle restarts immediately
    kernel_rdy = 1'b0;
    kick();
    watch(-1, -1, nr, fk, vk);
    chk("t3_vldk_a", 64'(vk), 26);
    kernel_rdy = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_ren_next", 64'(rom_r_en), 1);
    chk("t3_addr_next", 64'(rom_raddr), 0);
    chk("t3_vld_gap", 64'(kernel_vld), 0);
    watch(-1, -1, nr, fk, vk);
    chk("t3_reads", 64'(nr), 25);
    chk("t3_vldk_b", 64'(vk), 26);
    check_slots("t3_slot", 1'b0);
    @(negedge clk);
    chk("t3_idle", 64'(busy), 0);

    // 4: start pulses during READ are ignored
    kick();
    watch(5, 20, nr, fk, vk);
    chk("t4_reads", 64'(nr), 25);
    chk("t4_vldk", 64'(vk), 26);
    @(negedge clk);
    chk("t4_idle", 64'(busy), 0);
    cnt_en  = 0;
    cnt_vld = 0;
    for (int c = 0; c < 30; c++) begin
      if (rom_r_en) cnt_en++;
      if (kernel_vld) cnt_vld++;
      @(negedge clk);
    end
    chk("t4_no_restart", 64'(cnt_en), 0);
    chk("t4_single_vld", 64'(cnt_vld), 0);

    // 5: async reset mid-READ
    kick();
    repeat (12) @(negedge clk);
    chk("t5_pre_ren", 64'(rom_r_en), 1);
    chk("t5_pre_addr", 64'(rom_raddr), 12);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 0);
    chk("t5_ren", 64'(rom_r_en), 0);
    chk("t5_addr", 64'(rom_raddr), 0);
    chk("t5_vld", 64'(kernel_vld), 0);
    chk("t5_kdata", 64'(|kernel_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_stay_idle", 64'(busy), 0);
    kick();
    watch(-1, -1, nr, fk, vk);
    chk("t5_reads", 64'(nr), 25);
    chk("t5_vldk", 64'(vk), 26);
    check_slots("t5_slot", 1'b0);
    @(negedge clk);

    // 6: reloaded ROM overwrites every slot
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'hFFFF;
    kick();
    watch(-1, -1, nr, fk, vk);
    chk("t6_vldk", 64'(vk), 26);
    check_slots("t6_slot", 1'b1);
    @(negedge clk);
    chk("t6_idle", 64'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
